// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 4-digit segment scanner.
package seg_pkg;

  // Active-low bus values that leave the display dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } scan_state_e;

  // Camera value selected for the upstream segment decoder.
  localparam logic [1:0] SEL_ISO     = 2'b00;
  localparam logic [1:0] SEL_SHUTTER = 2'b01;
  localparam logic [1:0] SEL_FOCAL   = 2'b10;
  localparam logic [1:0] SEL_IND     = 2'b11;

  // One-hot-low digit enable; exactly one bit is low for any digit index.
  function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
    return AN_OFF ^ (4'b0001 << digit);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Per-slot cycle counter with blank-end and slot-end compares.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          run,
  output logic [CW-1:0] cnt,
  output logic          blank_end,
  output logic          slot_end
);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and wrap at the slot end.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == SLOT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register; the controller folds reset into clear.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign blank_end = (cnt_q == BLANK_LAST);
  assign slot_end  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode display with frame snapshot.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | display dark, waiting for enable
// ST_BLANK | start of a digit slot, all anodes off to avoid ghosting
// ST_SHOW  | current digit lit from the frame snapshot
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  input  logic       step_sel,
  output logic [7:0] seg_out,
  output logic [3:0] an_n,
  output logic [1:0] select_out,
  output logic       frame_start
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  scan_state_e     state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      seg_out_q, seg_out_d;
  logic [3:0]      an_q, an_d;
  logic            frame_start_q, frame_start_d;

  logic            tmr_clear;
  logic            tmr_run;
  logic            frame_entry;
  logic [CW-1:0]   slot_cnt;
  logic            blank_end;
  logic            slot_end;

  seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .clear     (tmr_clear),
    .run       (tmr_run),
    .cnt       (slot_cnt),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // Next state, digit, snapshot and timer control; reset then enable take priority.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    snap_d      = snap_q;
    tmr_clear   = 1'b0;
    tmr_run     = 1'b0;
    frame_entry = 1'b0;

    if (rst) begin
      state_d   = ST_IDLE;
      digit_d   = 2'd0;
      snap_d    = {4{SEG_BLANK}};
      tmr_clear = 1'b1;
    end else if (!enable) begin
      state_d   = ST_IDLE;
      digit_d   = 2'd0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_BLANK;
          digit_d     = 2'd0;
          tmr_clear   = 1'b1;
          frame_entry = 1'b1;
        end
        ST_BLANK: begin
          tmr_run = 1'b1;
          if (blank_end) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_end) begin
            state_d     = ST_BLANK;
            digit_d     = digit_q + 2'd1;
            tmr_clear   = 1'b1;
            frame_entry = (digit_q == 2'd3);
          end else begin
            tmr_run = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          digit_d   = 2'd0;
          tmr_clear = 1'b1;
        end
      endcase

      // Whole frame is latched at once so digits never mix old and new data.
      if (frame_entry) snap_d = {seg_in_4, seg_in_3, seg_in_2, seg_in_1};
    end
  end

  // Select counter and registered outputs derived from the upcoming state.
  always_comb begin
    sel_d         = rst ? SEL_ISO : sel_q + {1'b0, step_sel};
    seg_out_d     = SEG_BLANK;
    an_d          = AN_OFF;
    frame_start_d = frame_entry;
    if (state_d == ST_SHOW) begin
      seg_out_d = snap_d[digit_d];
      an_d      = an_for_digit(digit_d);
    end
  end

  // All state and output flops; reset values come through the _d logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      digit_q       <= 2'd0;
      snap_q        <= {4{SEG_BLANK}};
      sel_q         <= SEL_ISO;
      seg_out_q     <= SEG_BLANK;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      snap_q        <= snap_d;
      sel_q         <= sel_d;
      seg_out_q     <= seg_out_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The slot counter must sit at zero whenever the scanner is parked.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_IDLE) assert (slot_cnt == '0);
  end

  assign seg_out     = seg_out_q;
  assign an_n        = an_q;
  assign select_out  = sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] seg_in_1 = 8'hC0, seg_in_2 = 8'hF9, seg_in_3 = 8'hA4, seg_in_4 = 8'hB0;
  logic       step_sel = 1'b0;
  logic [7:0] seg_out;
  logic [3:0] an_n;
  logic [1:0] select_out;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, position within the 32-cycle frame, snapshot, select.
  bit         m_run = 0;
  int         m_pos = 0;
  logic [7:0] m_snap [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int         m_sel = 0;

  seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .seg_in_1(seg_in_1), .seg_in_2(seg_in_2), .seg_in_3(seg_in_3), .seg_in_4(seg_in_4),
    .step_sel(step_sel), .seg_out(seg_out), .an_n(an_n),
    .select_out(select_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (rst) begin
      m_run = 0; m_pos = 0; m_sel = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 8'hFF;
    end else begin
      m_sel = (m_sel + (step_sel ? 1 : 0)) % 4;
      if (!enable) begin
        m_run = 0; m_pos = 0;
      end else begin
        if (!m_run) begin
          m_run = 1; m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % FRAME;
        end
        if (m_pos == 0) begin
          m_snap[0] = seg_in_1; m_snap[1] = seg_in_2;
          m_snap[2] = seg_in_3; m_snap[3] = seg_in_4;
        end
      end
    end
  endtask

  function automatic bit m_lit();
    return m_run && ((m_pos % DC) >= BC);
  endfunction
  function automatic logic [7:0] m_seg();
    return m_lit() ? m_snap[m_pos / DC] : 8'hFF;
  endfunction
  function automatic logic [3:0] m_an();
    logic [3:0] one;
    one = 4'b0001;
    return m_lit() ? (4'hF ^ (one << (m_pos / DC))) : 4'hF;
  endfunction
  function automatic logic m_fs();
    return m_run && (m_pos == 0);
  endfunction

  // One clock: model follows the edge, outputs are then observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; step_sel = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; step_sel = 1'b1;
    do_reset();
    n_checks++;
    if (seg_out !== 8'hFF || an_n !== 4'hF || select_out !== 2'b00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: seg=%h an=%h sel=%b fs=%b, want FF F 00 0", seg_out, an_n, select_out, frame_start);
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_entry: fs=%b an=%h, want 1 F", frame_start, an_n);
    end
  endtask

  task automatic test_full_frame();
    int fs_t[$];
    logic [3:0] an_seq[$];
    logic [3:0] want_an [4];
    logic [3:0] last_an;
    want_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_in_1 = 8'hC0; seg_in_2 = 8'hF9; seg_in_3 = 8'hA4; seg_in_4 = 8'hB0;
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    last_an = 4'hF;
    for (int c = 0; c < 70; c++) begin
      tick();
      n_checks++;
      if (seg_out !== m_seg() || an_n !== m_an() || frame_start !== m_fs() || select_out !== 2'(m_sel)) begin
        n_fail++;
        $display("FAIL frame_cycle%0d: seg=%h an=%h fs=%b, want %h %h %b", c, seg_out, an_n, frame_start, m_seg(), m_an(), m_fs());
      end
      if (frame_start === 1'b1) fs_t.push_back(c);
      if (an_n !== 4'hF && an_n !== last_an && an_seq.size() < 4) an_seq.push_back(an_n);
      last_an = an_n;
    end
    n_checks++;
    if (fs_t.size() < 2 || (fs_t[1] - fs_t[0]) != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d frame_start pulses (gap %0d), want gap %0d", fs_t.size(),
               fs_t.size() >= 2 ? fs_t[1] - fs_t[0] : -1, FRAME);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= an_seq.size() || an_seq[i] !== want_an[i]) begin
        n_fail++;
        $display("FAIL an_sequence[%0d]: got %h, want %h", i, i < an_seq.size() ? an_seq[i] : 4'hx, want_an[i]);
      end
    end
  endtask

  task automatic test_tearing();
    int waited = 0;
    int frame_no = 0;
    while (!(m_run && m_pos == 10) && waited < 80) begin tick(); waited++; end
    n_checks++;
    if (waited >= 80) begin
      n_fail++;
      $display("FAIL tearing_wait: frame position 10 not reached, want reached");
    end
    seg_in_2 = 8'h92;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (m_run && m_pos == 0) frame_no++;
      if (m_run && (m_pos / DC) == 1 && (m_pos % DC) >= BC) begin
        n_checks++;
        if (seg_out !== (frame_no == 0 ? 8'hF9 : 8'h92)) begin
          n_fail++;
          $display("FAIL tearing_digit1 frame%0d: seg=%h, want %h", frame_no, seg_out, frame_no == 0 ? 8'hF9 : 8'h92);
        end
      end
    end
    seg_in_2 = 8'hF9;
  endtask

  task automatic test_select_step();
    logic [1:0] want [7];
    want = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step_sel = 1'b1;
      tick();
      step_sel = 1'b0;
      n_checks++;
      if (select_out !== want[i]) begin
        n_fail++;
        $display("FAIL select_pulse%0d: got %b, want %b", i, select_out, want[i]);
      end
      tick();
      n_checks++;
      if (select_out !== want[i]) begin
        n_fail++;
        $display("FAIL select_hold%0d: got %b, want %b", i, select_out, want[i]);
      end
    end
    step_sel = 1'b1;
    for (int i = 4; i < 7; i++) begin
      tick();
      n_checks++;
      if (select_out !== want[i]) begin
        n_fail++;
        $display("FAIL select_wide%0d: got %b, want %b", i, select_out, want[i]);
      end
    end
    step_sel = 1'b0;
    tick();
    n_checks++;
    if (select_out !== 2'b11) begin
      n_fail++;
      $display("FAIL select_after_wide: got %b, want 11", select_out);
    end
  endtask

  task automatic test_enable_drop();
    int waited = 0;
    enable = 1'b1;
    while (!(m_run && (m_pos / DC) == 2 && (m_pos % DC) >= BC + 1) && waited < 80) begin tick(); waited++; end
    n_checks++;
    if (an_n !== 4'hB || waited >= 80) begin
      n_fail++;
      $display("FAIL drop_precondition: an=%h waited=%0d, want B and under 80", an_n, waited);
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if (an_n !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_dark: an=%h seg=%h fs=%b, want F FF 0", an_n, seg_out, frame_start);
    end
    tick();
    enable = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL reenable_entry: fs=%b an=%h, want 1 F", frame_start, an_n);
    end
    tick(); tick();
    n_checks++;
    if (an_n !== 4'hE || seg_out !== m_snap[0]) begin
      n_fail++;
      $display("FAIL reenable_digit0: an=%h seg=%h, want E %h", an_n, seg_out, m_snap[0]);
    end
  endtask

  task automatic test_reset_priority();
    int waited = 0;
    enable = 1'b1;
    step_sel = 1'b1; tick(); tick(); step_sel = 1'b0;
    while (!m_lit() && waited < 40) begin tick(); waited++; end
    n_checks++;
    if (an_n === 4'hF || select_out !== 2'(m_sel)) begin
      n_fail++;
      $display("FAIL prio_precondition: an=%h sel=%b, want lit and %0d", an_n, select_out, m_sel);
    end
    rst = 1'b1; step_sel = 1'b1;
    tick();
    rst = 1'b0; step_sel = 1'b0;
    n_checks++;
    if (select_out !== 2'b00 || an_n !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: sel=%b an=%h seg=%h fs=%b, want 00 F FF 0", select_out, an_n, seg_out, frame_start);
    end
  endtask

  task automatic test_random_invariant();
    for (int c = 0; c < 10000; c++) begin
      enable   = ($urandom_range(0, 19) != 0);
      step_sel = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      seg_in_1 = 8'($urandom); seg_in_2 = 8'($urandom);
      seg_in_3 = 8'($urandom); seg_in_4 = 8'($urandom);
      tick();
      n_checks++;
      if (seg_out !== m_seg() || an_n !== m_an() || frame_start !== m_fs() || select_out !== 2'(m_sel)) begin
        n_fail++;
        $display("FAIL random_model c%0d: seg=%h an=%h fs=%b sel=%b, want %h %h %b %b",
                 c, seg_out, an_n, frame_start, select_out, m_seg(), m_an(), m_fs(), 2'(m_sel));
      end
      n_checks++;
      if ($countones(~an_n) > 1 || (an_n === 4'hF && seg_out !== 8'hFF)) begin
        n_fail++;
        $display("FAIL random_invariant c%0d: an=%h seg=%h, want at most one low anode and dark bus when off", c, an_n, seg_out);
      end
    end
    rst = 1'b0; step_sel = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_tearing();
    test_select_step();
    test_enable_drop();
    test_reset_priority();
    test_random_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 50000: clk cycles per digit slot, including the blank time.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500: anti-ghost blank cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < DIGIT_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: 1 = scan the display, 0 = display dark.
REQ-006 SHALL have ports seg_in_1..seg_in_4, input, 8 bits each: active-low segment patterns; bit7 = decimal point; seg_in_1 = rightmost digit.
REQ-007 SHALL have port step_sel, input, 1 bit: single-cycle, already-debounced request to advance the displayed camera value.
REQ-008 SHALL have port seg_out, output, 8 bits: active-low shared segment bus.
REQ-009 SHALL have port an_n, output, 4 bits: active-low digit enables; an_n[0] drives the seg_in_1 digit.
REQ-010 SHALL have port select_out, output, 2 bits: value select (00 ISO, 01 shutter, 10 focal, 11 indicator) fed to the segment decoder.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL implement the states IDLE, BLANK and SHOW, plus a 2-bit digit index and a slot counter cnt (0..DIGIT_CYCLES-1).
REQ-013 SHALL, in IDLE with enable=1, go to BLANK with digit=0 and cnt=0 on the next cycle.
REQ-014 SHALL, in BLANK or SHOW, increment cnt every cycle.
REQ-015 SHALL go from BLANK to SHOW when cnt reaches BLANK_CYCLES-1.
REQ-016 SHALL, in SHOW, go to BLANK with cnt=0 and digit=digit+1 mod 4 when cnt reaches DIGIT_CYCLES-1; digit 3 wraps to 0.
REQ-017 SHALL, with enable=0 in any state, enter IDLE next cycle with digit=0 and cnt=0.
REQ-018 SHALL define frame entry as entering BLANK with digit=0.
REQ-019 SHALL, on every frame entry, capture all four seg_in_* into a snapshot register in the same cycle; patterns shown during a frame come only from that snapshot, so there is no tearing.
REQ-020 SHALL assert frame_start for exactly the first BLANK cycle of digit 0.
REQ-021 SHALL drive, in IDLE and BLANK: seg_out=8'hFF and an_n=4'hF.
REQ-022 SHALL drive, in SHOW: seg_out = snapshot[digit], and an_n = all ones except bit[digit]=0.
REQ-023 SHALL register all outputs; seg_out, an_n and frame_start reflect the state of the same cycle with no combinational path from inputs.
REQ-024 SHALL increment select_out mod 4 on the cycle after step_sel=1 (11 wraps to 00), independent of enable and scan state.
REQ-025 SHALL treat step_sel held high for N cycles as N increments; debounce is the upstream block's job.
REQ-026 SHALL apply a new select_out to the display at the next frame entry, through the snapshot; the current frame finishes unchanged.
REQ-027 SHALL never assert more than one an_n bit low in any cycle, including state transitions.

Reset
REQ-028 SHALL, with rst=1, force next cycle: state IDLE, digit 0, cnt 0, snapshot 8'hFF x4, seg_out 8'hFF, an_n 4'hF, select_out 2'b00, frame_start 0.
REQ-029 SHALL give rst priority over enable and step_sel in the same cycle.
REQ-030 SHALL, on reset mid-SHOW, darken the display on the next cycle with no partial slot completed.
REQ-031 SHALL, after rst falls with enable=1, hold IDLE for one cycle and then make frame entry (frame_start=1) on the second cycle.

Structure
REQ-032 SHALL put in shared package seg_pkg: constants SEG_BLANK=8'hFF and AN_OFF=4'hF, the scan state enum, and the select code constants SEL_ISO, SEL_SHUTTER, SEL_FOCAL and SEL_IND.
REQ-033 SHALL isolate the slot counter and its compare logic in one sub-module, seg_scan_timer (inputs: clear, run; outputs: cnt, blank_end, slot_end).
REQ-034 SHALL keep the state machine, snapshot, output registers and select counter in seg_scan_ctrl.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2)
REQ-035 SHALL verify the full frame: seg_in_1..4 = C0/F9/A4/B0, enable=1 after reset. Required: per digit, 2 cycles dark then 6 cycles lit; an_n sequence E, D, B, 7; seg_out C0, F9, A4, B0; frame_start period 32 cycles.
REQ-036 SHALL verify tearing: change seg_in_2 from F9 to 92 at cycle 10 of the frame. Required: digit 1 still shows F9; 92 appears only after the next frame_start.
REQ-037 SHALL verify select stepping: four step_sel pulses plus one 3-cycle-wide pulse. Required: select_out goes 01, 10, 11, 00, then 01, 10, 11; each change lands one cycle after the pulse.
REQ-038 SHALL verify enable drop: enable=0 during SHOW of digit 2. Required: next cycle an_n=F and seg_out=FF; on re-enable, frame_start occurs 1 cycle later with digit 0.
REQ-039 SHALL verify reset priority: rst=1 and step_sel=1 together during SHOW. Required: next cycle select_out=00, an_n=F, seg_out=FF, no frame_start.
REQ-040 SHALL verify the safety invariant: random enable, step_sel and rst for 10k cycles. Required: an_n never has two or more bits low; seg_out=FF whenever an_n=F.
